// File: rtl/range_pkg.sv
// Shared types and default constants for the ultrasonic range sampler.
// The default cycle counts assume CLK_NS = 20.
package range_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT,
    S_CHECK,
    S_ACCUM,
    S_RECOVER,
    S_HOLD
  } state_t;

  typedef logic [11:0] dist_t;

  localparam int CLK_NS          = 20;
  localparam int PERIOD_CYC_DEF  = 3_000_000;
  localparam int TIMEOUT_CYC_DEF = 2_500_000;
  localparam int MIN_MM_DEF      = 20;
  localparam int MAX_MM_DEF      = 4000;

endpackage

// File: rtl/avg_ring.sv
// Moving-average ring of 2^AVG_LOG2 samples with a running sum.
// mean/full are look-ahead values: what the window holds once this cycle's push lands.
module avg_ring
  import range_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  clear,
  input  logic  push,
  input  dist_t sample,
  output dist_t mean,
  output logic  full
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = 12 + AVG_LOG2;
  localparam int FW    = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

  dist_t               ring_q [DEPTH];
  logic [AVG_LOG2-1:0] wr_q;
  logic [FW-1:0]       fill_q;
  logic [FW-1:0]       fill_nxt;
  logic [SW-1:0]       sum_q;
  logic [SW-1:0]       sum_nxt;

  // The sum always equals the sum of the ring entries, so the subtraction cannot underflow.
  always_comb begin
    sum_nxt  = sum_q - SW'(ring_q[wr_q]) + SW'(sample);
    fill_nxt = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;
  end

  assign mean = dist_t'(sum_nxt >> AVG_LOG2);
  assign full = (fill_nxt == FILL_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      wr_q   <= '0;
      fill_q <= '0;
      sum_q  <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      wr_q   <= '0;
      fill_q <= '0;
      sum_q  <= '0;
    end else if (push) begin
      ring_q[wr_q] <= sample;
      sum_q        <= sum_nxt;
      wr_q         <= wr_q + 1'b1;
      fill_q       <= fill_nxt;
    end
  end

endmodule

// File: rtl/range_sampler.sv
// Periodic measurement scheduler for the ultrasonic ranger: triggers, times out,
// range-filters and averages results, then offers them over a valid/ready port.
module range_sampler
  import range_pkg::*;
#(
  parameter int PERIOD_CYC  = PERIOD_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int AVG_LOG2    = 2,
  parameter int MIN_MM      = MIN_MM_DEF,
  parameter int MAX_MM      = MAX_MM_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        start_o,
  output logic        sensor_rst_n,
  input  logic        val_i,
  input  logic [11:0] dist_i,
  output logic [11:0] dist_o,
  output logic        dist_valid,
  input  logic        dist_ready,
  output logic        err_timeout,
  output logic        err_range,
  output logic        overrun,
  output state_t      state_dbg
);

  localparam int CW = $clog2(PERIOD_CYC);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(PERIOD_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(TIMEOUT_CYC - 1);
  localparam dist_t         MIN_D       = dist_t'(MIN_MM);
  localparam dist_t         MAX_D       = dist_t'(MAX_MM);

  state_t        state_q;
  state_t        state_nxt;
  logic [CW-1:0] period_cnt;
  logic [CW-1:0] tmo_cnt;
  dist_t         sample_q;
  logic          rec_cnt;
  logic          in_range;
  logic          push;
  logic          load;
  dist_t         mean;
  logic          full;

  assign state_dbg = state_q;
  assign in_range  = (sample_q >= MIN_D) && (sample_q <= MAX_D);
  assign load      = push & full;

  always_comb begin
    state_nxt    = state_q;
    start_o      = 1'b0;
    sensor_rst_n = 1'b1;
    err_timeout  = 1'b0;
    err_range    = 1'b0;
    push         = 1'b0;
    unique case (state_q)
      S_IDLE: if (en) state_nxt = S_TRIG;
      S_TRIG: begin
        start_o   = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (val_i)                    state_nxt = S_CHECK;
        else if (tmo_cnt == TMO_LAST) state_nxt = S_RECOVER;
      end
      S_CHECK: begin
        if (in_range) begin
          state_nxt = S_ACCUM;
        end else begin
          err_range = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_ACCUM: begin
        push      = 1'b1;
        state_nxt = S_HOLD;
      end
      S_RECOVER: begin
        sensor_rst_n = 1'b0;
        err_timeout  = ~rec_cnt;
        if (rec_cnt) state_nxt = S_HOLD;
      end
      S_HOLD: if (period_cnt == PERIOD_LAST) state_nxt = en ? S_TRIG : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Both counters read 0 during TRIG, so start pulses land exactly PERIOD_CYC apart.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      period_cnt <= '0;
      tmo_cnt    <= '0;
      sample_q   <= '0;
      rec_cnt    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      rec_cnt <= (state_q == S_RECOVER) && !rec_cnt;
      if (state_nxt == S_TRIG || state_q == S_IDLE) period_cnt <= '0;
      else                                          period_cnt <= period_cnt + 1'b1;
      if (state_nxt == S_TRIG)                             tmo_cnt <= '0;
      else if (state_q == S_TRIG || state_q == S_WAIT)     tmo_cnt <= tmo_cnt + 1'b1;
      if (state_q == S_WAIT && val_i) sample_q <= dist_i;
    end
  end

  avg_ring #(.AVG_LOG2(AVG_LOG2)) u_ring (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == S_IDLE),
    .push   (push),
    .sample (sample_q),
    .mean   (mean),
    .full   (full)
  );

  // Handshake: dist_o is transferred on any cycle with dist_valid & dist_ready.
  // A new result always loads; it counts as an overrun only if the old one was not taken that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dist_o     <= '0;
      dist_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load) begin
        dist_o     <= mean;
        dist_valid <= 1'b1;
        if (dist_valid && !dist_ready) overrun <= 1'b1;
      end else if (dist_valid && dist_ready) begin
        dist_valid <= 1'b0;
      end
      if (state_q == S_IDLE) overrun <= 1'b0;
    end
  end

endmodule
